wb_stage: RTL and testbench

- Write-back stage, directly downstream of the MEM/WB pipeline registers; consumes their register and signal outputs.
- Drives the register-file write port and owns the architectural HI/LO registers.
- Executes SYSCALL: either prints a value or halts.
- Keeps a retired-instruction counter and a halt state machine for the whole pipeline.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sat_counter.sv | 30 +++
 rtl/wb_stage.sv | 154 +++++++++++++++
 tb/tb_wb_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, architectural register numbers,
// SYSCALL codes and the write-back halt state type.
package cpu_pkg;

    localparam int          WORD_W       = 32;
    localparam logic [31:0] SYSCALL_HALT = 32'd10;
    localparam logic [4:0]  REG_RA       = 5'd31;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    // Return address written by JAL: the word after the jump.
    function automatic logic [WORD_W-1:0] link_addr(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous active-low clear that holds at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic         at_max_s;

    assign at_max_s = (count_r == {W{1'b1}});

    // Counter register: clear, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (en && !at_max_s) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/wb_stage.sv
// Write-back stage: register-file write port, architectural HI/LO, SYSCALL
// print/halt handling and the retired-instruction counter.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_CODE = SYSCALL_HALT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IR,
    input  logic [31:0]      PC,
    input  logic [31:0]      R1,
    input  logic [31:0]      R2,
    input  logic [31:0]      RD1,
    input  logic [31:0]      RD2,
    input  logic [4:0]       WbRegNum,
    input  logic             RegWrite,
    input  logic             LOWrite,
    input  logic             HIWrite,
    input  logic             JAL,
    input  logic             SYSCALL,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      hi,
    output logic [31:0]      lo,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    wb_state_e   state_r;
    wb_state_e   next_state_s;
    logic        valid_s;
    logic        print_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] disp_data_r;
    logic        disp_valid_r;
    logic        halt_r;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    // A bubble or anything arriving after halt is not an instruction.
    assign valid_s = (IR != 32'd0) && (state_r == RUN);

    // Register-file write port, same cycle as the instruction.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = WbRegNum;
        rf_wdata_s = R1;
        if (valid_s && RegWrite && (WbRegNum != 5'd0)) begin
            rf_we_s = 1'b1;
        end else begin
            rf_we_s = 1'b0;
        end
        if (JAL) begin
            rf_wdata_s = link_addr(PC);
        end else begin
            rf_wdata_s = R1;
        end
    end

    assign rf_we    = rf_we_s;
    assign rf_waddr = rf_waddr_s;
    assign rf_wdata = rf_wdata_s;

    // Halt FSM next state and print decision.
    always_comb begin
        next_state_s = state_r;
        print_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (valid_s && SYSCALL && (RD1 == HALT_CODE)) begin
                    next_state_s = HALTED;
                end else if (valid_s && SYSCALL) begin
                    next_state_s = RUN;
                    print_s      = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            HALTED: begin
                next_state_s = HALTED;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Halt FSM state register; halt mirrors the state it is entering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RUN;
            halt_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            halt_r  <= (next_state_s == HALTED);
        end
    end

    // HI/LO registers; a mult/div writes both in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (valid_s && HIWrite) begin
                hi_r <= R2;
            end else begin
                hi_r <= hi_r;
            end
            if (valid_s && LOWrite) begin
                lo_r <= R1;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    // Display latch and its one-cycle update strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_data_r  <= 32'd0;
            disp_valid_r <= 1'b0;
        end else if (print_s) begin
            disp_data_r  <= RD2;
            disp_valid_r <= 1'b1;
        end else begin
            disp_data_r  <= disp_data_r;
            disp_valid_r <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_retired (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (valid_s),
        .count(retired)
    );

    assign hi         = hi_r;
    assign lo         = lo_r;
    assign disp_data  = disp_data_r;
    assign disp_valid = disp_valid_r;
    assign halt       = halt_r;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Randomised self-checking bench for wb_stage against a behavioural model;
// a second instance with a 4-bit counter exercises saturation.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] IR, PC, R1, R2, RD1, RD2;
    logic [4:0]  WbRegNum;
    logic        RegWrite, LOWrite, HIWrite, JAL, SYSCALL;

    logic        rf_we, disp_valid, halt;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi, lo, disp_data, retired;

    logic        s_rf_we, s_disp_valid, s_halt;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata, s_hi, s_lo, s_disp_data;
    logic [3:0]  s_retired;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          known = 1'b0;
    bit          m_halted;
    logic [31:0] m_hi, m_lo, m_disp;
    bit          m_dv;
    int          m_cnt;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .PC(PC), .R1(R1), .R2(R2),
        .RD1(RD1), .RD2(RD2), .WbRegNum(WbRegNum), .RegWrite(RegWrite),
        .LOWrite(LOWrite), .HIWrite(HIWrite), .JAL(JAL), .SYSCALL(SYSCALL),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi(hi),
        .lo(lo), .disp_data(disp_data), .disp_valid(disp_valid), .halt(halt),
        .retired(retired)
    );

    wb_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .IR(IR), .PC(PC), .R1(R1), .R2(R2),
        .RD1(RD1), .RD2(RD2), .WbRegNum(WbRegNum), .RegWrite(RegWrite),
        .LOWrite(LOWrite), .HIWrite(HIWrite), .JAL(JAL), .SYSCALL(SYSCALL),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata), .hi(s_hi),
        .lo(s_lo), .disp_data(s_disp_data), .disp_valid(s_disp_valid), .halt(s_halt),
        .retired(s_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One instruction slot: drive, check combinational port, clock, check state.
    task automatic cyc(input bit rst, input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [4:0] wbn, input bit rw, input bit lw,
                       input bit hw, input bit jal, input bit sc);
        bit v;
        rst_n = ~rst; IR = ir; PC = pc; R1 = r1; R2 = r2; RD1 = rd1; RD2 = rd2;
        WbRegNum = wbn; RegWrite = rw; LOWrite = lw; HIWrite = hw; JAL = jal; SYSCALL = sc;
        #2;
        v = (ir != 32'd0) && !m_halted;
        if (known) begin
            chk("rf_we", {31'd0, rf_we}, {31'd0, v && rw && (wbn != 5'd0)});
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, wbn});
            chk("rf_wdata", rf_wdata, jal ? pc + 32'd4 : r1);
        end
        @(posedge clk);
        if (rst) begin
            known = 1'b1; m_halted = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
            m_disp = 32'd0; m_dv = 1'b0; m_cnt = 0;
        end else begin
            m_dv = 1'b0;
            if (v) begin
                m_cnt++;
                if (hw) m_hi = r2;
                if (lw) m_lo = r1;
                if (sc && rd1 == 32'd10) m_halted = 1'b1;
                else if (sc) begin m_disp = rd2; m_dv = 1'b1; end
            end
        end
        #1;
        if (known) begin
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("disp_data", disp_data, m_disp);
            chk("disp_valid", {31'd0, disp_valid}, {31'd0, m_dv});
            chk("halt", {31'd0, halt}, {31'd0, m_halted});
            chk("retired", retired, m_cnt);
            chk("retired_sat", {28'd0, s_retired}, (m_cnt > 15) ? 32'd15 : m_cnt);
        end
    endtask

    initial begin
        m_halted = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_disp = 32'd0; m_dv = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Ordinary write, write to $0, bubble
        cyc(0, 32'h00221820, 32'h00400000, 32'h1234, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0);
        chk("t1_retired", retired, 32'd1);
        cyc(0, 32'h00221820, 32'h00400004, 32'h55, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0);
        cyc(0, 32'h0, 32'h00400008, 32'h66, 0, 0, 0, 5'd4, 1, 1, 1, 0, 1);
        chk("t2_retired", retired, 32'd2);
        // JAL, then mult/div write of HI and LO
        cyc(0, 32'h0C100000, 32'h00400010, 32'h0, 0, 0, 0, 5'd31, 1, 0, 0, 1, 0);
        cyc(0, 32'h00430018, 32'h00400014, 32'h2, 32'hFFFFFFFF, 0, 0, 5'd0, 0, 1, 1, 0, 0);
        chk("t3_hi", hi, 32'hFFFFFFFF);
        // Print SYSCALL, strobe must drop on the next cycle
        cyc(0, 32'h0000000C, 32'h00400018, 0, 0, 32'd1, 32'h2A, 5'd0, 0, 0, 0, 0, 1);
        chk("t4_disp", disp_data, 32'h2A);
        cyc(0, 32'h00221820, 32'h0040001C, 32'h7, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0);
        chk("t4_pulse", {31'd0, disp_valid}, 32'd0);
        // Halt SYSCALL that also writes the register file
        cyc(0, 32'h0000000C, 32'h00400020, 32'h9, 0, 32'd10, 32'h77, 5'd2, 1, 0, 0, 0, 1);
        chk("t5_halt", {31'd0, halt}, 32'd1);
        for (int i = 0; i < 4; i++)
            cyc(0, 32'h0000000C, 32'h00400024, 32'h99, 32'h88, 32'd1, 32'h5, 5'd6, 1, 1, 1, 0, 1);
        cyc(1, 32'h0000000C, 0, 0, 0, 32'd10, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_reset_halt", {31'd0, halt}, 32'd0);
        // Saturation of the 4-bit instance
        for (int i = 0; i < 20; i++)
            cyc(0, 32'h00221820 + i, 32'h00400000, i, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0);
        chk("t6_sat", {28'd0, s_retired}, 32'd15);
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ir, rd1;
            ir  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rd1 = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom_range(0, 12);
            cyc($urandom_range(0, 29) == 0, ir, $urandom, $urandom, $urandom, rd1, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(0, 5) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_stage
